// File: rtl/accumulate_term_sequencer_if.sv
// accumulate_term_sequencer_if
//   Groups the term stream (valid/ready with data and add/sub tag) and the
//   FP adder/subtractor control bus used by accumulate_term_sequencer.
//
//   master : the sequencer side. It accepts terms, drives the adder operands
//            and controls, and receives the adder result.
//   slave  : the environment side. It supplies terms and hosts the adder.
//
//   Signals:
//     term_valid, term_data[31:0], term_sub : incoming term, sub=1 subtracts it
//     term_ready                            : sequencer accepts the term this cycle
//     adder_A/adder_B[31:0], adder_op       : adder operands, op 0=add 1=sub
//     adder_ce, adder_start                 : adder enable and start
//     adder_result[31:0], adder_finish      : adder outputs
interface accumulate_term_sequencer_if;
  logic        term_valid;
  logic [31:0] term_data;
  logic        term_sub;
  logic        term_ready;
  logic [31:0] adder_A;
  logic [31:0] adder_B;
  logic        adder_op;
  logic        adder_ce;
  logic        adder_start;
  logic [31:0] adder_result;
  logic        adder_finish;

  modport master (
    input  term_valid, term_data, term_sub, adder_result, adder_finish,
    output term_ready, adder_A, adder_B, adder_op, adder_ce, adder_start
  );

  modport slave (
    output term_valid, term_data, term_sub, adder_result, adder_finish,
    input  term_ready, adder_A, adder_B, adder_op, adder_ce, adder_start
  );
endinterface

// File: rtl/accumulate_term_sequencer.sv
// accumulate_term_sequencer
//   Serial reduction controller in front of a start-controlled FP adder/subtractor.
//   Accepts N_TERMS single-precision terms, each tagged add or subtract, feeds
//   every adder result back as the next A operand and publishes the final sum
//   with a one-cycle sum_valid pulse.
//
//   Parameters:
//     N_TERMS : terms per reduction (1..255)
//     ADD_LAT : cycles from stable operands to a valid adder_result
//     CNT_W   : counter width, must hold max(N_TERMS, ADD_LAT)
//
//   Ports:
//     clk       : rising-edge clock
//     rst       : asynchronous active-low reset
//     clear     : synchronous abort, drops any partial sum
//     bus       : term stream and adder bus (master modport)
//     sum       : last completed reduction, held until the next one
//     sum_valid : one-cycle pulse when sum updates
//     busy      : high in any state other than idle
//
//   Build option:
//     ZERO_SKIP_EN : when defined, +/-0 terms after the first one only advance
//                    the term count and never occupy the adder.
module accumulate_term_sequencer #(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ADD_LAT = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  accumulate_term_sequencer_if.master        bus,
  output logic [31:0]                        sum,
  output logic                               sum_valid,
  output logic                               busy
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitFirst,
    StWaitTerm,
    StIssue,
    StWaitAdd,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] NTermsCnt = CNT_W'(N_TERMS);
  localparam logic [CNT_W-1:0] LatLast   = CNT_W'(ADD_LAT - 1);
  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      opa_q, opa_d;
  logic [31:0]      opb_q, opb_d;
  logic             op_q, op_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;
  logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic [31:0]      sum_q, sum_d;
  logic             sum_valid_q, sum_valid_d;

  logic             term_ready;
  logic             accept;
  logic             skip_zero;
  logic [CNT_W-1:0] term_cnt_inc;
  logic             in_add;

  // Completion is timed by lat_cnt; finish only tracks start and cannot mark
  // the end of an individual operation.
  logic unused_finish;
  assign unused_finish = bus.adder_finish;

`ifdef ZERO_SKIP_EN
  assign skip_zero = (bus.term_data[30:0] == 31'd0);
`else
  assign skip_zero = 1'b0;
`endif

  assign term_ready   = ((state_q == StWaitFirst) || (state_q == StWaitTerm)) && !clear;
  assign accept       = bus.term_valid && term_ready;
  assign term_cnt_inc = term_cnt_q + CntOne;
  assign in_add       = (state_q == StIssue) || (state_q == StWaitAdd);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    op_d        = op_q;
    term_cnt_d  = term_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StWaitFirst;
      end

      StWaitFirst: begin
        if (accept) begin
          // First term seeds the accumulator directly; only its sign may flip.
          acc_d      = {bus.term_data[31] ^ bus.term_sub, bus.term_data[30:0]};
          term_cnt_d = CntOne;
          state_d    = (N_TERMS == 1) ? StDone : StWaitTerm;
        end
      end

      StWaitTerm: begin
        if (accept) begin
          term_cnt_d = term_cnt_inc;
          if (skip_zero) begin
            state_d = (term_cnt_inc == NTermsCnt) ? StDone : StWaitTerm;
          end else begin
            opa_d   = acc_q;
            opb_d   = bus.term_data;
            op_d    = bus.term_sub;
            state_d = StIssue;
          end
        end
      end

      StIssue: begin
        lat_cnt_d = '0;
        state_d   = StWaitAdd;
      end

      StWaitAdd: begin
        lat_cnt_d = lat_cnt_q + CntOne;
        if (lat_cnt_q == LatLast) begin
          acc_d   = bus.adder_result;
          state_d = (term_cnt_q == NTermsCnt) ? StDone : StWaitTerm;
        end
      end

      StDone: begin
        sum_d       = acc_q;
        sum_valid_d = 1'b1;
        term_cnt_d  = '0;
        state_d     = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort wins over everything, but a reduction finishing this very cycle
    // has already been published above.
    if (clear) begin
      state_d    = StIdle;
      acc_d      = '0;
      term_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      op_q        <= 1'b0;
      term_cnt_q  <= '0;
      lat_cnt_q   <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      op_q        <= op_d;
      term_cnt_q  <= term_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.term_ready  = term_ready;
  assign bus.adder_A     = opa_q;
  assign bus.adder_B     = opb_q;
  assign bus.adder_op    = op_q;
  assign bus.adder_ce    = in_add;
  assign bus.adder_start = in_add;

  assign sum       = sum_q;
  assign sum_valid = sum_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_accumulate_term_sequencer.sv
`timescale 1ns/1ps
// Bench for accumulate_term_sequencer. Five instances with different term
// counts share the term inputs; each has its own valid, clear and a real-valued
// FP adder model with a fixed pipeline latency.
module tb_accumulate_term_sequencer;
  localparam int NI  = 5;
  localparam int LAT = 4;

  function automatic int nt_of(input int g);
    case (g)
      0:       return 8;
      1:       return 3;
      2:       return 1;
      3:       return 2;
      default: return 4;
    endcase
  endfunction

  // IEEE single <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] b);
    real r;
    int  e;
    if (b[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return b[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real v);
    real         a;
    int          e;
    logic [22:0] m;
    if (v == 0.0) return 32'h0;
    a = (v < 0.0) ? -v : v;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {(v < 0.0), 8'(e), m};
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub);
    return r2f(sub ? (f2r(a) - f2r(b)) : (f2r(a) + f2r(b)));
  endfunction

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] tvalid = '0;
  logic [NI-1:0] clr = '0;
  logic [31:0]   term_data = '0;
  logic          term_sub = 1'b0;

  logic [NI-1:0] ready_a, start_a, ce_a, op_a, sv_a, busy_a;
  logic [31:0]   sum_a [NI];
  logic [31:0]   opa_a [NI];
  logic [31:0]   opb_a [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    accumulate_term_sequencer_if bus ();
    logic [31:0] pipe [LAT];

    assign bus.term_valid   = tvalid[g];
    assign bus.term_data    = term_data;
    assign bus.term_sub     = term_sub;
    assign bus.adder_result = pipe[LAT-1];
    assign bus.adder_finish = 1'b0;

    always @(posedge clk) begin
      if (bus.adder_ce) begin
        pipe[0] <= fp_add(bus.adder_A, bus.adder_B, bus.adder_op);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
    end

    accumulate_term_sequencer #(
      .N_TERMS (nt_of(g)),
      .ADD_LAT (LAT),
      .CNT_W   (8)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clr[g]),
      .bus       (bus),
      .sum       (sum_a[g]),
      .sum_valid (sv_a[g]),
      .busy      (busy_a[g])
    );

    assign ready_a[g] = bus.term_ready;
    assign start_a[g] = bus.adder_start;
    assign ce_a[g]    = bus.adder_ce;
    assign op_a[g]    = bus.adder_op;
    assign opa_a[g]   = bus.adder_A;
    assign opb_a[g]   = bus.adder_B;
  end

  // Monitor: counts sum_valid pulses and adder start windows per instance.
  int            cyc = 0;
  int            sv_cnt  [NI];
  int            win_cnt [NI];
  int            sv_cyc  [NI];
  logic [31:0]   sv_sum  [NI];
  logic [7:0]    op_log  [NI];
  logic [NI-1:0] start_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (sv_a[g]) begin
        sv_cnt[g] = sv_cnt[g] + 1;
        sv_cyc[g] = cyc;
        sv_sum[g] = sum_a[g];
      end
      if (start_a[g] && !start_prev[g]) begin
        win_cnt[g] = win_cnt[g] + 1;
        op_log[g]  = {op_log[g][6:0], op_a[g]};
      end
    end
    start_prev = start_a;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs(input int g);
    return {26'd0, sum_a[g], opa_a[g], opb_a[g], op_a[g], ce_a[g], start_a[g],
            sv_a[g], ready_a[g], busy_a[g]};
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Presents one term to instance g; returns the cycle in which it was accepted.
  task automatic send(input int g, input logic [31:0] d, input logic s, output int acc_c);
    int n;
    n         = 0;
    acc_c     = -1;
    term_data = d;
    term_sub  = s;
    tvalid    = '0;
    tvalid[g] = 1'b1;
    forever begin
      @(negedge clk);
      if (ready_a[g]) break;
      n++;
      if (n > 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL term_accept_timeout: inst %0d never ready", g);
        break;
      end
    end
    acc_c = cyc;
    @(posedge clk);
    #1;
    tvalid = '0;
  endtask

  task automatic wait_sv(input int g, input int base);
    int n;
    n = 0;
    while (sv_cnt[g] == base && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sv_cnt[g] == base) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sum_valid_timeout: inst %0d got no pulse, want one", g);
    end
  endtask

  typedef struct packed {
    logic [31:0] d0;
    logic        s0;
    logic [31:0] d1;
    logic        s1;
    logic [31:0] d2;
    logic        s2;
    logic [31:0] sum;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] d0, input logic s0, input logic [31:0] d1,
                              input logic s1, input logic [31:0] d2, input logic s2,
                              input logic [31:0] sum);
    vec_t v;
    v.d0 = d0; v.s0 = s0; v.d1 = d1; v.s1 = s1; v.d2 = d2; v.s2 = s2; v.sum = sum;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [4];
    int          ac, first, base_sv, base_win, exp_win, nz, k;
    real         ref_sum;
    logic [31:0] d;
    logic        s;

    tbl[0] = mk(32'h40400000, 1'b0, 32'h3F000000, 1'b1, 32'h40000000, 1'b0, 32'h40900000);
    tbl[1] = mk(32'h3F800000, 1'b1, 32'h40200000, 1'b0, 32'h3E800000, 1'b1, 32'h3FA00000);
    tbl[2] = mk(32'h3FC00000, 1'b1, 32'h3F000000, 1'b1, 32'h40800000, 1'b1, 32'hC0C00000);
    tbl[3] = mk(32'h41000000, 1'b0, 32'h3F400000, 1'b0, 32'h41800000, 1'b1, 32'hC0E80000);

    // Reset and release.
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int g = 0; g < NI; g++) check($sformatf("reset_outputs_%0d", g), outs(g), '0);
    #1 rst = 1'b1;
    #1 check("idle_after_release", {126'd0, ready_a[0], busy_a[0]}, '0);
    @(negedge clk);
    check("wait_first_ready", {123'd0, ready_a}, {123'd0, {NI{1'b1}}});

    // Eight back-to-back 1.0 terms.
    sync();
    base_sv  = sv_cnt[0];
    base_win = win_cnt[0];
    first    = 0;
    for (int i = 0; i < 8; i++) begin
      send(0, 32'h3F800000, 1'b0, ac);
      if (i == 0) first = ac;
    end
    wait_sv(0, base_sv);
    check("sum8_value", sv_sum[0], 32'h41000000);
    check("sum8_latency", sv_cyc[0] - first, 44);
    check("sum8_windows", win_cnt[0] - base_win, 7);
    repeat (5) @(negedge clk);
    check("sum8_single_pulse", sv_cnt[0] - base_sv, 1);

    // Table of three-term reductions.
    for (int r = 0; r < 4; r++) begin
      sync();
      base_sv  = sv_cnt[1];
      base_win = win_cnt[1];
      send(1, tbl[r].d0, tbl[r].s0, ac);
      send(1, tbl[r].d1, tbl[r].s1, ac);
      send(1, tbl[r].d2, tbl[r].s2, ac);
      wait_sv(1, base_sv);
      check($sformatf("tbl%0d_sum", r), sv_sum[1], tbl[r].sum);
      check($sformatf("tbl%0d_ops", r), op_log[1][1:0], {tbl[r].s1, tbl[r].s2});
      check($sformatf("tbl%0d_windows", r), win_cnt[1] - base_win, 2);
    end

    // Single-term reduction with subtract.
    sync();
    base_sv = sv_cnt[2];
    send(2, 32'h40800000, 1'b1, ac);
    wait_sv(2, base_sv);
    check("n1_sum", sv_sum[2], 32'hC0800000);
    check("n1_latency", sv_cyc[2] - ac, 2);
    check("n1_no_start", win_cnt[2], 0);

    // Clear coinciding with the finishing cycle still publishes.
    sync();
    base_sv = sv_cnt[2];
    send(2, 32'h3F800000, 1'b0, ac);
    clr[2] = 1'b1;
    sync();
    clr[2] = 1'b0;
    wait_sv(2, base_sv);
    check("clear_in_done_sum", sv_sum[2], 32'h3F800000);

    // Abort during the add of the second term, then a fresh 1.0 + 1.0.
    sync();
    base_sv = sv_cnt[3];
    send(3, 32'h3F800000, 1'b0, ac);
    send(3, 32'h3F800000, 1'b0, ac);
    sync();
    sync();
    check("clear_pre_start", start_a[3], 1'b1);
    clr[3] = 1'b1;
    sync();
    clr[3] = 1'b0;
    check("clear_start_drop", {126'd0, start_a[3], busy_a[3]}, '0);
    sync();
    check("clear_ready_before", ready_a[3], 1'b1);
    clr[3] = 1'b1;
    #1 check("clear_forces_ready_low", ready_a[3], 1'b0);
    clr[3] = 1'b0;
    repeat (8) @(negedge clk);
    check("clear_no_pulse", sv_cnt[3] - base_sv, 0);
    sync();
    send(3, 32'h3F800000, 1'b0, ac);
    send(3, 32'h3F800000, 1'b0, ac);
    wait_sv(3, base_sv);
    check("clear_fresh_sum", sv_sum[3], 32'h40000000);
    check("clear_fresh_pulses", sv_cnt[3] - base_sv, 1);

    // Zero terms: skipped or added depending on the build option.
    sync();
    base_sv  = sv_cnt[4];
    base_win = win_cnt[4];
    send(4, 32'h3F800000, 1'b0, ac);
    send(4, 32'h00000000, 1'b0, ac);
    send(4, 32'h80000000, 1'b0, ac);
    send(4, 32'h40000000, 1'b0, ac);
    wait_sv(4, base_sv);
`ifdef ZERO_SKIP_EN
    exp_win = 1;
`else
    exp_win = 3;
`endif
    check("zero_sum", sv_sum[4], 32'h40400000);
    check("zero_windows", win_cnt[4] - base_win, exp_win);

    // Asynchronous reset in the middle of an add.
    sync();
    base_sv = sv_cnt[0];
    send(0, 32'h3F800000, 1'b0, ac);
    send(0, 32'h40000000, 1'b0, ac);
    @(negedge clk);
    @(negedge clk);
    check("rst_pre_start", start_a[0], 1'b1);
    rst = 1'b0;
    #1 check("rst_mid_outputs", outs(0), '0);
    #1 rst = 1'b1;
    #1 check("rst_release_idle", ready_a[0], 1'b0);
    @(negedge clk);
    check("rst_release_ready", ready_a[0], 1'b1);
    repeat (10) @(negedge clk);
    check("rst_no_pulse", sv_cnt[0] - base_sv, 0);

    // Random reductions against a real-valued reference sum.
    for (int r = 0; r < 6; r++) begin
      sync();
      base_sv  = sv_cnt[0];
      base_win = win_cnt[0];
      ref_sum  = 0.0;
      nz       = 0;
      for (int i = 0; i < 8; i++) begin
        k = int'($urandom_range(64, 0));
        if (i == 0 && k == 0) k = 1;
        d     = r2f(real'(k) / 4.0);
        d[31] = 1'($urandom_range(1, 0));
        s     = 1'($urandom_range(1, 0));
        if (i > 0 && d[30:0] == 31'd0) nz++;
        ref_sum = s ? (ref_sum - f2r(d)) : (ref_sum + f2r(d));
        repeat ($urandom_range(2, 0)) @(posedge clk);
        #1;
        send(0, d, s, ac);
      end
      wait_sv(0, base_sv);
`ifdef ZERO_SKIP_EN
      exp_win = 7 - nz;
`else
      exp_win = 7;
`endif
      check($sformatf("rand%0d_sum", r), sv_sum[0], r2f(ref_sum));
      check($sformatf("rand%0d_windows", r), win_cnt[0] - base_win, exp_win);
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
